// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point compressor/decoder pair.
// Holds the field widths, the decoder state encoding, the sample payload
// layout and the sign-application helper.
package fp_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned OUT_W = 12;

  // Decoder state encoding.
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [ST_W-1:0] ST_SIGN  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  // One compressed sample as carried on the input bus.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } sample_t;

  // Turn a magnitude into two's complement; a zero magnitude stays zero
  // regardless of sign, so no negative zero is ever produced.
  function automatic logic [OUT_W-1:0] apply_sign(input logic sign,
                                                  input logic [OUT_W-1:0] mag);
    logic [OUT_W-1:0] neg;
    neg = OUT_W'(~mag + OUT_W'(1));
    return sign ? neg : mag;
  endfunction

endpackage

// File: rtl/fp_to_lin_if.sv
// Sample-in / result-out handshake bundle for fp_to_lin.
//   in_valid/in_ready/in_sign/in_exp/in_sig : compressed sample input
//   out_valid/out_ready/d                   : decoded two's-complement result
// slave  : the decoder side
// master : the producer/consumer side driving the decoder
interface fp_to_lin_if;
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [SIG_W-1:0] in_sig;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] d;

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, d
  );

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, d
  );

endinterface

// File: rtl/fp_to_lin.sv
// Iterative floating-point-to-linear decoder.
// Accepts (sign, exp, sig), rebuilds magnitude = sig << exp one bit per
// cycle, applies the sign and holds the 12-bit two's-complement result
// until the consumer takes it.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fp_to_lin_if.slave (sample input and result output handshakes)
module fp_to_lin
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fp_to_lin_if.slave  bus
);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_next;
  logic             sign_q;
  logic             sign_next;
  logic [OUT_W-1:0] shreg;
  logic [OUT_W-1:0] shreg_next;
  logic [EXP_W-1:0] cnt;
  logic [EXP_W-1:0] cnt_next;
  logic [OUT_W-1:0] d_q;
  logic [OUT_W-1:0] d_next;
  logic             out_valid_q;
  logic             out_valid_next;
  sample_t          in_smp;
  logic             accept;

  // in_ready is combinational so that it falls the instant rst rises.
  assign bus.in_ready  = (state == ST_IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;

  assign in_smp = '{sign: bus.in_sign, exp: bus.in_exp, sig: bus.in_sig};
  assign accept = bus.in_valid & bus.in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_next     = state;
    sign_next      = sign_q;
    shreg_next     = shreg;
    cnt_next       = cnt;
    d_next         = d_q;
    out_valid_next = out_valid_q;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          sign_next  = in_smp.sign;
          shreg_next = {{(OUT_W-SIG_W){1'b0}}, in_smp.sig};
          cnt_next   = in_smp.exp;
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt != '0) begin
          shreg_next = {shreg[OUT_W-2:0], 1'b0};
          cnt_next   = cnt - EXP_W'(1);
        end else begin
          state_next = ST_SIGN;
        end
      end

      ST_SIGN: begin
        d_next         = apply_sign(sign_q, shreg);
        out_valid_next = 1'b1;
        state_next     = ST_DONE;
      end

      ST_DONE: begin
        // d keeps its value after the handshake; only out_valid drops.
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q      <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sign_q      <= sign_next;
      shreg       <= shreg_next;
      cnt         <= cnt_next;
      d_q         <= d_next;
      out_valid_q <= out_valid_next;
    end
  end

endmodule
